namespace_stream_mux: RTL and testbench
=======================================

NAMESPACE_STREAM_MUX -- requirements
Module: namespace_stream_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning lane element width in bits.
REQ-002 SHALL have parameter NUM_LANES, default 4, meaning SIMD lanes per beat.
REQ-003 SHALL have parameter LEN_W, default 16, meaning command length counter width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid/cmd_ready, input/output, 1 each, meaning command handshake.
REQ-007 SHALL have port cmd_sel, input, 3, meaning namespace: 0 OBUF, 1 IBUF, 2 VMEM1, 3 VMEM2, 4 IMM, 5 EXT, 6-7 illegal.
REQ-008 SHALL have port cmd_len, input, LEN_W, meaning beats to transfer.
REQ-009 SHALL have port src_data, input, 6*NUM_LANES*DATA_WIDTH, meaning per-source beat; source k occupies slice k (IMM slice unused).
REQ-010 SHALL have ports src_valid/src_ready, input/output, 6 each, meaning per-source handshake.
REQ-011 SHALL have port imm_data, input, DATA_WIDTH, meaning immediate scalar.
REQ-012 SHALL have ports out_data, output, NUM_LANES*DATA_WIDTH; out_valid/out_last, output, 1; out_ready, input, 1.
REQ-013 SHALL have ports busy and err_sel, output, 1 each.

Function
REQ-014 SHALL implement FSM IDLE/STREAM; cmd_ready=1 only in IDLE.
REQ-015 SHALL, on cmd_valid&&cmd_ready, latch sel and len, latch imm_data if sel=4, enter STREAM.
REQ-016 SHALL treat sel 6/7 as illegal: pulse err_sel for exactly one cycle, drop the command, stay IDLE.
REQ-017 SHALL treat len=0 as no-op: accepted, no beats, no out_last, remain IDLE.
REQ-018 SHALL hold a 2-entry output FIFO (data+last); src_ready[sel]=1 in STREAM when FIFO holds <2 entries; all other src_ready bits 0.
REQ-019 SHALL push a beat when src_valid[sel]&&src_ready[sel]; for IMM, imm treated always valid and broadcast to all lanes.
REQ-020 SHALL decrement remaining count per push; the push at remaining=1 carries last=1 and returns FSM to IDLE next cycle.
REQ-021 SHALL drive out_valid = FIFO non-empty, with head data/last; pop on out_valid&&out_ready.
REQ-022 SHALL give 1-cycle latency: a beat pushed in cycle t is on out_data in t+1 when FIFO was empty.
REQ-023 SHALL keep out_data/out_last stable while out_valid&&!out_ready.
REQ-024 SHALL allow simultaneous push and pop when full-minus-pop; full FIFO with pop in same cycle still blocks push (ready registered from count).
REQ-025 SHALL allow a new command in IDLE while the FIFO drains previous beats; ordering preserved.
REQ-026 SHALL drive busy = (state==STREAM) || FIFO non-empty.
REQ-027 SHALL sustain one beat per cycle with out_ready held high.

Reset
REQ-028 SHALL, on reset_n low (asynchronous, including mid-stream), force IDLE, empty FIFO, zero count and latched sel/imm.
REQ-029 SHALL reset outputs to: cmd_ready=1 after release, src_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, err_sel=0.

Structure
REQ-030 SHALL take namespace encodings (NS_OBUF..NS_EXT, NUM_NS=6) from shared package simd_ns_pkg.
REQ-031 SHALL implement the 2-entry FIFO as sub-module simd_skid_fifo (parameterised width).

Verification
REQ-032 SHALL cover: sel=2, len=3, VMEM1 valid always, out_ready=1 -> 3 beats consecutive, out_last on 3rd, busy low 1 cycle after last pop.
REQ-033 SHALL cover: sel=4, imm_data=0xDEADBEEF, len=2 -> 2 beats, every lane 0xDEADBEEF, imm change after accept ignored.
REQ-034 SHALL cover: sel=7 -> err_sel high one cycle, no src_ready, stays IDLE; sel=1 len=0 -> no output.
REQ-035 SHALL cover: sel=0, len=4, out_ready low 5 cycles -> 2 beats buffered, src_ready low, no data loss/reorder after release.
REQ-036 SHALL cover: reset_n low mid-stream (beat 2 of 5) -> out_valid=0 immediately, cmd_ready=1 after release, next command correct.

Source files
------------

// File: rtl/simd_ns_pkg.sv
// Shared namespace encodings and FSM state type for the SIMD stream mux.
// Pure definitions, no logic or latency of its own.
// Carries no flow control; the users of this package apply the encodings.
package simd_ns_pkg;

  localparam int NUM_NS = 6;

  localparam logic [2:0] NS_OBUF  = 3'd0;
  localparam logic [2:0] NS_IBUF  = 3'd1;
  localparam logic [2:0] NS_VMEM1 = 3'd2;
  localparam logic [2:0] NS_VMEM2 = 3'd3;
  localparam logic [2:0] NS_IMM   = 3'd4;
  localparam logic [2:0] NS_EXT   = 3'd5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } mux_state_e;

  // Encodings 6 and 7 name no source.
  function automatic logic ns_legal(input logic [2:0] sel);
    return sel < 3'(NUM_NS);
  endfunction

endpackage

// File: rtl/simd_skid_fifo.sv
// Two-entry FIFO that decouples the selected source from the output port.
// Latency: a push is visible at head_data in the next cycle.
// Backpressure: no internal guard; the caller pushes only below 2 entries and pops only when non-empty.
module simd_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt_q;

  // Storage, pointers and occupancy; entries are cleared so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt_q;

endmodule

// File: rtl/namespace_stream_mux.sv
// Streams cmd_len beats from one of six namespaces (or a broadcast immediate) to a single output port.
// Latency: 1 cycle from source handshake to out_valid when the output FIFO is empty.
// Backpressure: out_ready stalls a 2-entry FIFO; the selected src_ready drops once it holds 2 entries.
module namespace_stream_mux
  import simd_ns_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 4,
  parameter int LEN_W      = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [2:0]                            cmd_sel,
  input  logic [LEN_W-1:0]                      cmd_len,
  input  logic [NUM_NS*NUM_LANES*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_NS-1:0]                     src_valid,
  output logic [NUM_NS-1:0]                     src_ready,
  input  logic [DATA_WIDTH-1:0]                 imm_data,
  output logic [NUM_LANES*DATA_WIDTH-1:0]       out_data,
  output logic                                  out_valid,
  output logic                                  out_last,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  err_sel
);

  localparam int BEAT_W = NUM_LANES * DATA_WIDTH;
  localparam int FIFO_W = BEAT_W + 1;

  mux_state_e             state;
  logic [2:0]             sel_q;
  logic [LEN_W-1:0]       rem_q;
  logic [DATA_WIDTH-1:0]  imm_q;
  logic                   err_q;

  logic [BEAT_W-1:0]      sel_beat;
  logic                   sel_valid;
  logic [1:0]             fifo_count;
  logic [FIFO_W-1:0]      fifo_head;
  logic                   has_room;
  logic                   push;
  logic                   pop;
  logic                   beat_last;

  // Room is judged from the registered count, so a full FIFO blocks a push even while it pops.
  assign has_room  = (fifo_count != 2'd2);
  assign push      = (state == ST_STREAM) && has_room && sel_valid;
  assign pop       = out_valid && out_ready;
  assign beat_last = (rem_q == LEN_W'(1));

  // Pick the latched namespace's beat and valid; the immediate is always valid and fills every lane.
  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < NUM_NS; k++) begin
      if (sel_q == 3'(k)) begin
        sel_beat  = src_data[k*BEAT_W +: BEAT_W];
        sel_valid = src_valid[k];
      end
    end
    if (sel_q == NS_IMM) begin
      sel_beat  = {NUM_LANES{imm_q}};
      sel_valid = 1'b1;
    end
  end

  // Only the latched namespace sees ready, and only while streaming with FIFO room.
  always_comb begin
    src_ready = '0;
    if ((state == ST_STREAM) && has_room) begin
      for (int k = 0; k < NUM_NS; k++) begin
        if (sel_q == 3'(k)) begin
          src_ready[k] = 1'b1;
        end
      end
    end
  end

  // Command FSM: accept in IDLE, drop illegal selects with a one-cycle error pulse, count beats in STREAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sel_q <= 3'd0;
      rem_q <= '0;
      imm_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_valid) begin
          if (!ns_legal(cmd_sel)) begin
            err_q <= 1'b1;
          end else if (cmd_len != '0) begin
            sel_q <= cmd_sel;
            rem_q <= cmd_len;
            if (cmd_sel == NS_IMM) begin
              imm_q <= imm_data;
            end
            state <= ST_STREAM;
          end
        end
      end else begin
        if (push) begin
          rem_q <= rem_q - LEN_W'(1);
          if (beat_last) begin
            state <= ST_IDLE;
          end
        end
      end
    end
  end

  simd_skid_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({beat_last, sel_beat}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign cmd_ready = (state == ST_IDLE);
  assign err_sel   = err_q;
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_head[BEAT_W-1:0];
  assign out_last  = fifo_head[BEAT_W];
  assign busy      = (state == ST_STREAM) || out_valid;

endmodule

// File: tb/tb_namespace_stream_mux.sv
// Directed bench for namespace_stream_mux at default parameters (4 lanes x 32 bits).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_namespace_stream_mux;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_sel;
  logic [15:0]  cmd_len;
  logic [767:0] src_data;
  logic [5:0]   src_valid;
  logic [5:0]   src_ready;
  logic [31:0]  imm_data;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         err_sel;

  int total;
  int bad;

  namespace_stream_mux #(
    .DATA_WIDTH (32),
    .NUM_LANES  (4),
    .LEN_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .imm_data  (imm_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .err_sel   (err_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane l of beat n from source k reads {k, n, l, A5}.
  function automatic logic [127:0] pat(input int k, input int n);
    logic [127:0] r;
    for (int l = 0; l < 4; l++) begin
      r[l*32 +: 32] = {8'(k), 8'(n), 8'(l), 8'hA5};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic [127:0] v);
    src_data[k*128 +: 128] = v;
  endtask

  initial begin
    logic [127:0] imm_bcast;
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_sel   = 3'd0;
    cmd_len   = 16'd0;
    src_data  = '0;
    src_valid = 6'b0;
    imm_data  = 32'h0;
    out_ready = 1'b1;
    imm_bcast = {4{32'hDEADBEEF}};

    // Reset values
    tick();
    chk("rst_src_ready", 128'(src_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_last",  128'(out_last),  128'(0));
    chk("rst_out_data",  out_data,        128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_err_sel",   128'(err_sel),   128'(0));
    reset_n = 1'b1;
    tick();
    chk("rel_cmd_ready", 128'(cmd_ready), 128'(1));

    // VMEM1, len 3, source always valid, sink always ready
    cmd_valid = 1'b1; cmd_sel = 3'd2; cmd_len = 16'd3;
    src_valid = 6'b000100; set_src(2, pat(2, 0));
    tick();
    cmd_valid = 1'b0;
    chk("a_cmd_ready_stream", 128'(cmd_ready), 128'(0));
    chk("a_src_ready",        128'(src_ready), 128'(6'b000100));
    chk("a_busy",             128'(busy),      128'(1));
    tick();
    chk("a_b0_valid", 128'(out_valid), 128'(1));
    chk("a_b0_data",  out_data,        pat(2, 0));
    chk("a_b0_last",  128'(out_last),  128'(0));
    set_src(2, pat(2, 1));
    tick();
    chk("a_b1_valid", 128'(out_valid), 128'(1));
    chk("a_b1_data",  out_data,        pat(2, 1));
    chk("a_b1_last",  128'(out_last),  128'(0));
    set_src(2, pat(2, 2));
    tick();
    chk("a_b2_valid",     128'(out_valid), 128'(1));
    chk("a_b2_data",      out_data,        pat(2, 2));
    chk("a_b2_last",      128'(out_last),  128'(1));
    chk("a_idle_ready",   128'(cmd_ready), 128'(1));
    chk("a_src_ready_lo", 128'(src_ready), 128'(0));
    chk("a_busy_drain",   128'(busy),      128'(1));
    src_valid = 6'b0;
    tick();
    chk("a_end_valid", 128'(out_valid), 128'(0));
    chk("a_end_busy",  128'(busy),      128'(0));

    // Immediate broadcast, len 2; imm_data change after accept must not leak through
    cmd_valid = 1'b1; cmd_sel = 3'd4; cmd_len = 16'd2; imm_data = 32'hDEADBEEF;
    tick();
    cmd_valid = 1'b0; imm_data = 32'h12345678;
    chk("b_src_ready", 128'(src_ready), 128'(6'b010000));
    tick();
    chk("b_b0_valid", 128'(out_valid), 128'(1));
    chk("b_b0_data",  out_data,        imm_bcast);
    chk("b_b0_last",  128'(out_last),  128'(0));
    tick();
    chk("b_b1_data", out_data,       imm_bcast);
    chk("b_b1_last", 128'(out_last), 128'(1));
    tick();
    chk("b_end_valid", 128'(out_valid), 128'(0));
    chk("b_end_busy",  128'(busy),      128'(0));

    // Illegal select 7, then a zero-length IBUF command
    cmd_valid = 1'b1; cmd_sel = 3'd7; cmd_len = 16'd5; src_valid = 6'b111111;
    tick();
    cmd_valid = 1'b0;
    chk("c_err_hi",    128'(err_sel),   128'(1));
    chk("c_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("c_src_ready", 128'(src_ready), 128'(0));
    tick();
    chk("c_err_lo",    128'(err_sel),   128'(0));
    chk("c_err_busy",  128'(busy),      128'(0));
    cmd_valid = 1'b1; cmd_sel = 3'd1; cmd_len = 16'd0;
    tick();
    cmd_valid = 1'b0;
    chk("c_len0_ready",     128'(cmd_ready), 128'(1));
    chk("c_len0_src_ready", 128'(src_ready), 128'(0));
    chk("c_len0_busy",      128'(busy),      128'(0));
    tick();
    chk("c_len0_valid", 128'(out_valid), 128'(0));
    chk("c_len0_err",   128'(err_sel),   128'(0));
    src_valid = 6'b0;

    // OBUF, len 4, sink stalled 5 cycles: 2 beats buffered then clean drain
    cmd_valid = 1'b1; cmd_sel = 3'd0; cmd_len = 16'd4; out_ready = 1'b0;
    src_valid = 6'b000001; set_src(0, pat(0, 0));
    tick();
    cmd_valid = 1'b0;
    tick();
    set_src(0, pat(0, 1));
    tick();
    set_src(0, pat(0, 2));
    chk("d_full_src_ready", 128'(src_ready), 128'(0));
    chk("d_full_valid",     128'(out_valid), 128'(1));
    chk("d_hold_data0",     out_data,        pat(0, 0));
    tick();
    chk("d_hold_data1",     out_data,        pat(0, 0));
    chk("d_hold_last",      128'(out_last),  128'(0));
    tick();
    chk("d_hold_src_ready", 128'(src_ready), 128'(0));
    chk("d_hold_data2",     out_data,        pat(0, 0));
    out_ready = 1'b1;
    tick();
    chk("d_b1_data",      out_data,        pat(0, 1));
    chk("d_b1_src_ready", 128'(src_ready), 128'(6'b000001));
    tick();
    chk("d_b2_data", out_data,       pat(0, 2));
    chk("d_b2_last", 128'(out_last), 128'(0));
    set_src(0, pat(0, 3));
    tick();
    chk("d_b3_data", out_data,       pat(0, 3));
    chk("d_b3_last", 128'(out_last), 128'(1));
    src_valid = 6'b0;
    tick();
    chk("d_end_valid", 128'(out_valid), 128'(0));
    chk("d_end_busy",  128'(busy),      128'(0));

    // VMEM2, len 5, asynchronous reset while beat 2 is in flight
    cmd_valid = 1'b1; cmd_sel = 3'd3; cmd_len = 16'd5;
    src_valid = 6'b001000; set_src(3, pat(3, 0));
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("e_b0_data", out_data, pat(3, 0));
    set_src(3, pat(3, 1));
    tick();
    chk("e_b1_valid", 128'(out_valid), 128'(1));
    chk("e_b1_data",  out_data,        pat(3, 1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("e_rst_valid",     128'(out_valid), 128'(0));
    chk("e_rst_busy",      128'(busy),      128'(0));
    chk("e_rst_src_ready", 128'(src_ready), 128'(0));
    tick();
    reset_n = 1'b1;
    src_valid = 6'b0;
    #1;
    chk("e_rel_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("e_rel_valid",     128'(out_valid), 128'(0));
    tick();
    cmd_valid = 1'b1; cmd_sel = 3'd5; cmd_len = 16'd2;
    src_valid = 6'b100000; set_src(5, pat(5, 0));
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("e_n0_data", out_data,       pat(5, 0));
    chk("e_n0_last", 128'(out_last), 128'(0));
    set_src(5, pat(5, 1));
    tick();
    chk("e_n1_data", out_data,       pat(5, 1));
    chk("e_n1_last", 128'(out_last), 128'(1));
    src_valid = 6'b0;
    tick();
    chk("e_end_valid", 128'(out_valid), 128'(0));
    chk("e_end_busy",  128'(busy),      128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
